mc_ctrl: RTL and testbench



---
 rtl/mc_ctrl.sv | 233 +++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle MIPS control unit.
// Steps each instruction through FETCH / DECODE / EXEC / MEM / WB, one
// datapath phase per clock. It also runs a req/ready handshake with a
// unified, variable-latency instruction/data memory.
// Ports:
//   clk, rstn            clock, asynchronous active-low reset
//   Op, Funct            IR[31:26] / IR[5:0] (stable from DECODE onward)
//   Zero                 ALU zero flag of the current cycle
//   mem_ready            memory completes the current access this cycle
//   mem_req, MemWrite    memory request / write qualifier
//   IorD                 memory address source (0 PC, 1 ALUOut)
//   PCWrite, IRWrite     PC load / IR+MDR load strobes
//   RegWrite             register file write strobe
//   ALUSrcA, ALUSrcB     ALU operand selects
//   EXTOp, ALUOp         extender mode / ALU operation
//   NPCOp, WDSel, GPRSel next-PC source, write-data source, dest register
//   instr_done, illegal  end-of-instruction pulse / unsupported opcode pulse
//   state                current state code (debug)
module mc_ctrl (
  input  logic       clk,
  input  logic       rstn,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       MemWrite,
  output logic       IorD,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       EXTOp,
  output logic [3:0] ALUOp,
  output logic [1:0] NPCOp,
  output logic [1:0] WDSel,
  output logic [1:0] GPRSel,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,  S_FETCH  = 4'd1, S_DECODE = 4'd2, S_EXEC  = 4'd3,
    S_MEMADR = 4'd4,  S_MEMRD  = 4'd5, S_MEMWB  = 4'd6, S_MEMWR = 4'd7,
    S_ALUWB  = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10
  } state_e;

  localparam logic [3:0] ALU_NOP  = 4'b0000, ALU_ADD = 4'b0001, ALU_SUB  = 4'b0010,
                         ALU_AND  = 4'b0011, ALU_OR  = 4'b0100, ALU_SLT  = 4'b0101,
                         ALU_SLTU = 4'b0110, ALU_LUI = 4'b1010;

  state_e     state_q, state_d;

  logic       r_alu_s, i_alu_s, i_ext_s;
  logic [3:0] r_aluop_s, i_aluop_s;
  logic       is_r_s, is_jr_s, is_jalr_s, is_lw_s, is_sw_s;
  logic       is_beq_s, is_bne_s, is_j_s, is_jal_s;

  // Instruction decode: R-type funct table and I-type ALU opcode table.
  always_comb begin
    r_alu_s   = 1'b1;
    r_aluop_s = ALU_NOP;
    case (Funct)
      6'b100000, 6'b100001: r_aluop_s = ALU_ADD;   // add, addu
      6'b100010, 6'b100011: r_aluop_s = ALU_SUB;   // sub, subu
      6'b100100:            r_aluop_s = ALU_AND;
      6'b100101:            r_aluop_s = ALU_OR;
      6'b101010:            r_aluop_s = ALU_SLT;
      6'b101011:            r_aluop_s = ALU_SLTU;
      default:              r_alu_s   = 1'b0;
    endcase
    i_alu_s   = 1'b1;
    i_ext_s   = 1'b0;
    i_aluop_s = ALU_NOP;
    case (Op)
      6'b001000: begin i_aluop_s = ALU_ADD; i_ext_s = 1'b1; end   // addi
      6'b001100: i_aluop_s = ALU_AND;                             // andi
      6'b001101: i_aluop_s = ALU_OR;                              // ori
      6'b001010: begin i_aluop_s = ALU_SLT; i_ext_s = 1'b1; end   // slti
      6'b001111: i_aluop_s = ALU_LUI;                             // lui
      default:   i_alu_s   = 1'b0;
    endcase
  end

  assign is_r_s    = (Op == 6'b000000) && r_alu_s;
  assign is_jr_s   = (Op == 6'b000000) && (Funct == 6'b001000);
  assign is_jalr_s = (Op == 6'b000000) && (Funct == 6'b001001);
  assign is_lw_s   = (Op == 6'b100011);
  assign is_sw_s   = (Op == 6'b101011);
  assign is_beq_s  = (Op == 6'b000100);
  assign is_bne_s  = (Op == 6'b000101);
  assign is_j_s    = (Op == 6'b000010);
  assign is_jal_s  = (Op == 6'b000011);

  // State register; reset forces IDLE, which zeroes every output at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs, with instruction-dependent fields.
  always_comb begin
    state_d    = state_q;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    IorD       = 1'b0;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    EXTOp      = 1'b0;
    ALUOp      = ALU_NOP;
    NPCOp      = 2'b00;
    WDSel      = 2'b00;
    GPRSel     = 2'b00;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        ALUSrcB = 2'b01;
        ALUOp   = ALU_ADD;
        if (mem_ready) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Branch target PC+4+(imm<<2) is precomputed into ALUOut here.
        ALUSrcB = 2'b11;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        if (is_lw_s || is_sw_s)                            state_d = S_MEMADR;
        else if (is_r_s || i_alu_s)                        state_d = S_EXEC;
        else if (is_beq_s || is_bne_s)                     state_d = S_BRANCH;
        else if (is_j_s || is_jal_s || is_jr_s || is_jalr_s) state_d = S_JUMP;
        else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (Op == 6'b000000) begin
          ALUSrcB = 2'b00;
          ALUOp   = r_aluop_s;
        end else begin
          ALUSrcB = 2'b10;
          EXTOp   = i_ext_s;
          ALUOp   = i_aluop_s;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        GPRSel     = (Op == 6'b000000) ? 2'b00 : 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        EXTOp   = 1'b1;
        ALUOp   = ALU_ADD;
        state_d = is_lw_s ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        IorD    = 1'b1;
        state_d = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        WDSel      = 2'b01;
        GPRSel     = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUOp      = ALU_SUB;
        NPCOp      = 2'b01;
        PCWrite    = (is_beq_s & Zero) | (is_bne_s & ~Zero);
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        // The PC already holds PC+4, so the link value is taken from it.
        PCWrite    = 1'b1;
        instr_done = 1'b1;
        NPCOp      = (is_jr_s || is_jalr_s) ? 2'b11 : 2'b10;
        if (is_jal_s) begin
          RegWrite = 1'b1;
          WDSel    = 2'b10;
          GPRSel   = 2'b10;
        end else if (is_jalr_s) begin
          RegWrite = 1'b1;
          WDSel    = 2'b10;
          GPRSel   = 2'b00;
        end else begin
          RegWrite = 1'b0;
        end
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl. For each instruction, a reference model
// builds the expected per-cycle output trace from the instruction class and
// the chosen memory wait counts. The bench then replays that trace against
// the DUT one cycle at a time.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic [5:0] Op, Funct;
  logic       Zero, mem_ready;
  logic       mem_req, MemWrite, IorD, PCWrite, IRWrite, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       EXTOp;
  logic [3:0] ALUOp;
  logic [1:0] NPCOp, WDSel, GPRSel;
  logic       instr_done, illegal;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  mc_ctrl dut (
    .clk(clk), .rstn(rstn), .Op(Op), .Funct(Funct), .Zero(Zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .MemWrite(MemWrite), .IorD(IorD), .PCWrite(PCWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .NPCOp(NPCOp), .WDSel(WDSel), .GPRSel(GPRSel),
    .instr_done(instr_done), .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic req, mw, iord, pcw, irw, rw, asa;
    logic [1:0] asb;
    logic ext;
    logic [3:0] alu;
    logic [1:0] npc, wd, gpr;
    logic done, ill;
  } exp_t;

  typedef struct {
    exp_t e;
    logic rdy;
    logic zr;
    logic ir_valid;
  } step_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_BNE = 5,
                 K_J = 6, K_JAL = 7, K_JR = 8, K_JALR = 9, K_ILL = 10;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    logic [3:0] alu;
    logic       ext;
  } ins_t;

  ins_t  tbl [25];
  step_t tr [$];
  exp_t  dut_vec;

  assign dut_vec = {state, mem_req, MemWrite, IorD, PCWrite, IRWrite, RegWrite, ALUSrcA,
                    ALUSrcB, EXTOp, ALUOp, NPCOp, WDSel, GPRSel, instr_done, illegal};

  task automatic init_tbl();
    tbl[0]  = '{6'h00, 6'h20, K_R,    4'd1,  1'b0};  // add
    tbl[1]  = '{6'h00, 6'h21, K_R,    4'd1,  1'b0};  // addu
    tbl[2]  = '{6'h00, 6'h22, K_R,    4'd2,  1'b0};  // sub
    tbl[3]  = '{6'h00, 6'h23, K_R,    4'd2,  1'b0};  // subu
    tbl[4]  = '{6'h00, 6'h24, K_R,    4'd3,  1'b0};  // and
    tbl[5]  = '{6'h00, 6'h25, K_R,    4'd4,  1'b0};  // or
    tbl[6]  = '{6'h00, 6'h2a, K_R,    4'd5,  1'b0};  // slt
    tbl[7]  = '{6'h00, 6'h2b, K_R,    4'd6,  1'b0};  // sltu
    tbl[8]  = '{6'h00, 6'h08, K_JR,   4'd0,  1'b0};  // jr
    tbl[9]  = '{6'h00, 6'h09, K_JALR, 4'd0,  1'b0};  // jalr
    tbl[10] = '{6'h08, 6'h15, K_I,    4'd1,  1'b1};  // addi
    tbl[11] = '{6'h0c, 6'h2a, K_I,    4'd3,  1'b0};  // andi
    tbl[12] = '{6'h0d, 6'h00, K_I,    4'd4,  1'b0};  // ori
    tbl[13] = '{6'h0a, 6'h08, K_I,    4'd5,  1'b1};  // slti
    tbl[14] = '{6'h0f, 6'h3f, K_I,    4'd10, 1'b0};  // lui
    tbl[15] = '{6'h23, 6'h11, K_LW,   4'd0,  1'b0};  // lw
    tbl[16] = '{6'h2b, 6'h22, K_SW,   4'd0,  1'b0};  // sw
    tbl[17] = '{6'h04, 6'h20, K_BEQ,  4'd0,  1'b0};  // beq
    tbl[18] = '{6'h05, 6'h09, K_BNE,  4'd0,  1'b0};  // bne
    tbl[19] = '{6'h02, 6'h08, K_J,    4'd0,  1'b0};  // j
    tbl[20] = '{6'h03, 6'h01, K_JAL,  4'd0,  1'b0};  // jal
    tbl[21] = '{6'h3f, 6'h20, K_ILL,  4'd0,  1'b0};  // unknown opcode
    tbl[22] = '{6'h00, 6'h3f, K_ILL,  4'd0,  1'b0};  // unknown funct
    tbl[23] = '{6'h09, 6'h00, K_ILL,  4'd0,  1'b0};  // addiu (unsupported)
    tbl[24] = '{6'h00, 6'h00, K_ILL,  4'd0,  1'b0};  // sll (unsupported)
  endtask

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input exp_t e, input logic rdy, input logic zr, input logic irv);
    step_t s;
    s.e = e; s.rdy = rdy; s.zr = zr; s.ir_valid = irv;
    tr.push_back(s);
  endtask

  // Reference model: expected cycle-by-cycle behaviour for one instruction.
  task automatic build(input ins_t ins, input int wf, input int wm, input logic z);
    exp_t e;
    tr.delete();
    e = '0; e.st = 4'd1; e.req = 1'b1; e.asb = 2'b01; e.alu = 4'd1;
    for (int k = 0; k < wf; k++) push(e, 1'b0, rbit(), 1'b0);
    e.pcw = 1'b1; e.irw = 1'b1;
    push(e, 1'b1, rbit(), 1'b0);
    e = '0; e.st = 4'd2; e.asb = 2'b11; e.ext = 1'b1; e.alu = 4'd1;
    if (ins.kind == K_ILL) begin e.ill = 1'b1; e.done = 1'b1; end
    push(e, rbit(), rbit(), 1'b1);
    case (ins.kind)
      K_R, K_I: begin
        e = '0; e.st = 4'd3; e.asa = 1'b1; e.alu = ins.alu;
        e.asb = (ins.kind == K_R) ? 2'b00 : 2'b10;
        e.ext = (ins.kind == K_R) ? 1'b0 : ins.ext;
        push(e, rbit(), rbit(), 1'b1);
        e = '0; e.st = 4'd8; e.rw = 1'b1; e.done = 1'b1;
        e.gpr = (ins.kind == K_R) ? 2'b00 : 2'b01;
        push(e, rbit(), rbit(), 1'b1);
      end
      K_LW, K_SW: begin
        e = '0; e.st = 4'd4; e.asa = 1'b1; e.asb = 2'b10; e.ext = 1'b1; e.alu = 4'd1;
        push(e, rbit(), rbit(), 1'b1);
        e = '0; e.req = 1'b1; e.iord = 1'b1;
        e.st = (ins.kind == K_LW) ? 4'd5 : 4'd7;
        e.mw = (ins.kind == K_SW);
        for (int k = 0; k < wm; k++) push(e, 1'b0, rbit(), 1'b1);
        e.done = (ins.kind == K_SW);
        push(e, 1'b1, rbit(), 1'b1);
        if (ins.kind == K_LW) begin
          e = '0; e.st = 4'd6; e.rw = 1'b1; e.wd = 2'b01; e.gpr = 2'b01; e.done = 1'b1;
          push(e, rbit(), rbit(), 1'b1);
        end
      end
      K_BEQ, K_BNE: begin
        e = '0; e.st = 4'd9; e.asa = 1'b1; e.alu = 4'd2; e.npc = 2'b01; e.done = 1'b1;
        e.pcw = (ins.kind == K_BEQ) ? z : ~z;
        push(e, rbit(), z, 1'b1);
      end
      K_J, K_JAL, K_JR, K_JALR: begin
        e = '0; e.st = 4'd10; e.pcw = 1'b1; e.done = 1'b1;
        e.npc = (ins.kind == K_J || ins.kind == K_JAL) ? 2'b10 : 2'b11;
        if (ins.kind == K_JAL)  begin e.rw = 1'b1; e.wd = 2'b10; e.gpr = 2'b10; end
        if (ins.kind == K_JALR) begin e.rw = 1'b1; e.wd = 2'b10; e.gpr = 2'b00; end
        push(e, rbit(), rbit(), 1'b1);
      end
      default: ;
    endcase
  endtask

  // Replays the first n steps of the trace (all steps when n < 0).
  task automatic run_trace(input string name, input ins_t ins, input int n);
    int lim;
    lim = (n < 0) ? tr.size() : n;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      Op        = tr[i].ir_valid ? ins.op : 6'($urandom);
      Funct     = tr[i].ir_valid ? ins.fn : 6'($urandom);
      mem_ready = tr[i].rdy;
      Zero      = tr[i].zr;
      #1;
      vectors++;
      if (dut_vec !== tr[i].e) begin
        miscompares++;
        $display("FAIL %s step %0d: got %h, expected %h", name, i, dut_vec, tr[i].e);
      end
    end
  endtask

  task automatic check_zero(input string name);
    vectors++;
    if (dut_vec !== '0) begin
      miscompares++;
      $display("FAIL %s: got %h, expected 0", name, dut_vec);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; Op = 6'h00; Funct = 6'h20; Zero = 1'b0; mem_ready = 1'b1;
    #1;
    check_zero("reset_async");
    repeat (3) begin
      @(negedge clk); #1;
      check_zero("reset_hold");
    end
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check_zero("reset_idle");
  endtask

  task automatic test_directed();
    build(tbl[0], 0, 0, 1'b0);  run_trace("add", tbl[0], -1);
    build(tbl[15], 0, 2, 1'b0); run_trace("lw_wait2", tbl[15], -1);
    build(tbl[17], 0, 0, 1'b1); run_trace("beq_taken", tbl[17], -1);
    build(tbl[18], 0, 0, 1'b1); run_trace("bne_not_taken", tbl[18], -1);
    build(tbl[20], 0, 0, 1'b0); run_trace("jal", tbl[20], -1);
    build(tbl[8], 0, 0, 1'b0);  run_trace("jr", tbl[8], -1);
    build(tbl[21], 0, 0, 1'b0); run_trace("illegal_op", tbl[21], -1);
    build(tbl[16], 1, 0, 1'b0); run_trace("sw_fetch_wait", tbl[16], -1);
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 120; n++) begin
      int idx;
      idx = $urandom_range(0, 24);
      build(tbl[idx], $urandom_range(0, 2), $urandom_range(0, 3), rbit());
      run_trace("random", tbl[idx], -1);
    end
  endtask

  task automatic test_reset_midwrite();
    // FETCH, DECODE, MEMADR, then the first MEMWR wait cycle
    build(tbl[16], 0, 3, 1'b0);
    run_trace("sw_pre_abort", tbl[16], 4);
    rstn = 1'b0;
    #1;
    check_zero("abort_memwr");
    @(negedge clk); #1;
    check_zero("abort_hold");
    rstn = 1'b1;
    build(tbl[1], 0, 0, 1'b0);
    run_trace("addu_after_abort", tbl[1], -1);
  endtask

  initial begin
    init_tbl();
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midwrite();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
